avalon_mem_arbiter: RTL

- Two-master to one-slave Avalon-MM arbiter. It shares the single memory port between the CPU instruction-fetch master (read-only) and the CPU data master (read/write).
- Sits between the MIPS core's two bus interfaces and the unified RAM model or memory controller.
- Holds a grant for the full duration of a transaction, including any number of slave waitrequest stall cycles.
- Serves both masters fairly, or with fixed data priority when configured.

---
 rtl/avalon_mem_pkg.sv | 36 +++
 rtl/avalon_mem_arbiter_if.sv | 44 ++++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/avalon_mem_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/avalon_mem_pkg.sv
// rtl/avalon_mem_pkg.sv - shared state/master types and grant constants for the arbiter
package avalon_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      INSTR = 1'b0,
      DATA  = 1'b1
   } master_id_t;

   localparam logic [1:0]  GRANT_NONE       = 2'b00;
   localparam logic [1:0]  GRANT_I          = 2'b01;
   localparam logic [1:0]  GRANT_D          = 2'b10;
   localparam logic [31:0] TIMEOUT_READDATA = 32'hDEADBEEF;

   function automatic arb_state_t grant_to_state(input logic [1:0] g);
      case (g)
         GRANT_I: return GNT_I;
         GRANT_D: return GNT_D;
         default: return IDLE;
      endcase
   endfunction

   function automatic logic [1:0] state_to_grant(input arb_state_t s);
      case (s)
         GNT_I:   return GRANT_I;
         GNT_D:   return GRANT_D;
         default: return GRANT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/avalon_mem_arbiter_if.sv
// rtl/avalon_mem_arbiter_if.sv - fetch, data and memory-side Avalon-MM signals of the arbiter
interface avalon_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   instr_address;
   logic                instr_read;
   logic                instr_waitrequest;
   logic [DATA_W-1:0]   instr_readdata;

   logic [ADDR_W-1:0]   data_address;
   logic                data_read;
   logic                data_write;
   logic [DATA_W/8-1:0] data_byteenable;
   logic [DATA_W-1:0]   data_writedata;
   logic                data_waitrequest;
   logic [DATA_W-1:0]   data_readdata;

   logic [ADDR_W-1:0]   mem_address;
   logic                mem_read;
   logic                mem_write;
   logic [DATA_W/8-1:0] mem_byteenable;
   logic [DATA_W-1:0]   mem_writedata;
   logic                mem_waitrequest;
   logic [DATA_W-1:0]   mem_readdata;

   // Arbiter view
   modport slave (
      input  instr_address, instr_read,
      input  data_address, data_read, data_write, data_byteenable, data_writedata,
      input  mem_waitrequest, mem_readdata,
      output instr_waitrequest, instr_readdata, data_waitrequest, data_readdata,
      output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
   );

   // Environment view: CPU masters plus memory
   modport master (
      output instr_address, instr_read,
      output data_address, data_read, data_write, data_byteenable, data_writedata,
      output mem_waitrequest, mem_readdata,
      input  instr_waitrequest, instr_readdata, data_waitrequest, data_readdata,
      input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata
   );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester picker: round-robin on last_served, or fixed data priority
module rr_arbiter2
   import avalon_mem_pkg::*;
#(
   parameter int DATA_PRIORITY = 0
) (
   input  logic       req_i,
   input  logic       req_d,
   input  master_id_t last_served,
   output logic [1:0] grant
);
   always_comb begin
      grant = GRANT_NONE;
      if (req_i && req_d) begin
         grant = ((DATA_PRIORITY != 0) || (last_served == INSTR)) ? GRANT_D : GRANT_I;
      end else if (req_d) begin
         grant = GRANT_D;
      end else if (req_i) begin
         grant = GRANT_I;
      end
   end
endmodule

// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - two-master to one-slave Avalon-MM arbiter
// Defining ARB_TIMEOUT_EN adds a stall watchdog and the sticky timeout_err output.
module avalon_mem_arbiter
   import avalon_mem_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int DATA_PRIORITY  = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   avalon_mem_arbiter_if.slave bus,
`ifdef ARB_TIMEOUT_EN
   output logic                timeout_err,
`endif
   output logic [1:0]          grant
);
   arb_state_t        state_q, state_d;
   master_id_t        last_q, last_d;
   logic [1:0]        grant_q, grant_d;
   logic [DATA_W-1:0] instr_rd_q, instr_rd_d;
   logic [DATA_W-1:0] data_rd_q, data_rd_d;

   logic              req_i, req_d, granted_i, granted_d, gnt_req, other_req;
   logic              done, abort, timeout_hit;
   logic [1:0]        pick_idle, pick_done;
   master_id_t        done_id;
   logic [DATA_W-1:0] rsp_data;

   assign req_i     = bus.instr_read;
   assign req_d     = bus.data_read | bus.data_write;
   assign granted_i = (state_q == GNT_I);
   assign granted_d = (state_q == GNT_D);
   assign gnt_req   = (granted_i & req_i) | (granted_d & req_d);
   assign abort     = (granted_i & ~req_i) | (granted_d & ~req_d);
   assign done      = gnt_req & (~bus.mem_waitrequest | timeout_hit);
   assign other_req = granted_i ? req_d : req_i;
   assign done_id   = granted_d ? DATA : INSTR;
   assign rsp_data  = timeout_hit ? DATA_W'(TIMEOUT_READDATA) : bus.mem_readdata;
   assign grant     = grant_q;

   rr_arbiter2 #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick_idle (
      .req_i(req_i), .req_d(req_d), .last_served(last_q), .grant(pick_idle)
   );

   // Picks the follow-on grant as if the completing master had just been served
   rr_arbiter2 #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick_done (
      .req_i(req_i), .req_d(req_d), .last_served(done_id), .grant(pick_done)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_err_q, timeout_err_d;

   assign timeout_hit = gnt_req & bus.mem_waitrequest & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = timeout_err_q | timeout_hit;

   always_comb begin
      cnt_d         = cnt_q;
      timeout_err_d = timeout_err_q | timeout_hit;
      if ((state_d != state_q) || done || !gnt_req) begin
         cnt_d = '0;
      end else if (bus.mem_waitrequest) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q         <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign timeout_hit        = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      instr_rd_d = instr_rd_q;
      data_rd_d  = data_rd_q;
      case (state_q)
         IDLE: state_d = grant_to_state(pick_idle);
         GNT_I, GNT_D: begin
            if (abort) begin
               state_d = IDLE;
            end else if (done) begin
               last_d = done_id;
               if (granted_i) instr_rd_d = rsp_data;
               else           data_rd_d  = rsp_data;
               state_d = other_req ? grant_to_state(pick_done) : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      grant_d = state_to_grant(state_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         last_q     <= INSTR;
         grant_q    <= GRANT_NONE;
         instr_rd_q <= '0;
         data_rd_q  <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         instr_rd_q <= instr_rd_d;
         data_rd_q  <= data_rd_d;
      end
   end

   // Slave command and responses follow the granted master combinationally
   always_comb begin
      bus.mem_read          = 1'b0;
      bus.mem_write         = 1'b0;
      bus.mem_address       = {ADDR_W{1'b0}};
      bus.mem_byteenable    = '0;
      bus.mem_writedata     = '0;
      bus.instr_waitrequest = 1'b1;
      bus.data_waitrequest  = 1'b1;
      bus.instr_readdata    = instr_rd_q;
      bus.data_readdata     = data_rd_q;
      if (granted_i) begin
         bus.mem_read          = bus.instr_read;
         bus.mem_address       = bus.instr_address;
         bus.mem_byteenable    = '1;
         bus.instr_waitrequest = bus.mem_waitrequest & ~timeout_hit;
         bus.instr_readdata    = rsp_data;
      end else if (granted_d) begin
         bus.mem_read          = bus.data_read & ~bus.data_write;
         bus.mem_write         = bus.data_write;
         bus.mem_address       = bus.data_address;
         bus.mem_byteenable    = bus.data_byteenable;
         bus.mem_writedata     = bus.data_writedata;
         bus.data_waitrequest  = bus.mem_waitrequest & ~timeout_hit;
         bus.data_readdata     = rsp_data;
      end
   end
endmodule
